dma_engine: RTL

DMA_ENGINE -- requirements
Module: dma_engine

---
 rtl/dma_engine_pkg.sv | 19 +
 rtl/dma_engine.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dma_engine_pkg.sv
// Shared definitions for the DMA copy engine: FSM state encoding and
// default width/limit constants used as parameter defaults by dma_engine.
package dma_engine_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_ADDR_WIDTH     = 16;
    localparam int DEFAULT_LEN_WIDTH      = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

endpackage

// File: rtl/dma_engine.sv
// Single-channel word-copy DMA engine. Reads one word from src, writes it to
// dst, and repeats for length words with a single outstanding request to the
// memory controller. Addresses wrap modulo 2^ADDR_WIDTH.
// Optional feature: define DMA_TIMEOUT_EN to add a wait-state watchdog that
// aborts a stalled transfer after TIMEOUT_CYCLES cycles and sets error.
module dma_engine
    import dma_engine_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH      = DEFAULT_LEN_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] src_reg, src_next;
    logic [ADDR_WIDTH-1:0] dst_reg, dst_next;
    logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  error_reg, error_next;
    logic                  timeout_hit;

`ifdef DMA_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              in_wait;

    assign in_wait     = (state_reg == ST_RD_WAIT) || (state_reg == ST_WR_WAIT);
    // Fires on the last permitted wait cycle when the controller is still silent.
    assign timeout_hit = in_wait && !mem_valid && (wait_cnt_reg == WAIT_LAST);

    // Wait counter counts only inside wait states, so it is zero on every entry.
    always_comb begin
        wait_cnt_next = '0;
        if (in_wait && !mem_valid) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    // No watchdog: wait states last as long as the controller needs.
    assign timeout_hit = 1'b0;
`endif

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            rem_reg   <= '0;
            data_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            rem_reg   <= rem_next;
            data_reg  <= data_next;
            error_reg <= error_next;
        end
    end

    // Next-state, datapath updates and memory request outputs.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
        error_next = error_reg;
        mem_en     = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        done       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    error_next = 1'b0;
                    src_next   = src_addr;
                    dst_next   = dst_addr;
                    rem_next   = length;
                    state_next = (length == '0) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                mem_en     = 1'b1;
                mem_addr   = src_reg;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_valid) begin
                    data_next  = mem_rdata;
                    state_next = ST_WR_REQ;
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_WR_REQ: begin
                mem_en     = 1'b1;
                mem_wr_en  = 1'b1;
                mem_addr   = dst_reg;
                mem_wdata  = data_reg;
                state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mem_valid) begin
                    src_next   = src_reg + ADDR_WIDTH'(1);
                    dst_next   = dst_reg + ADDR_WIDTH'(1);
                    rem_next   = rem_reg - LEN_WIDTH'(1);
                    state_next = (rem_reg > LEN_WIDTH'(1)) ? ST_RD_REQ : ST_FINISH;
                end else if (timeout_hit) begin
                    error_next = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == ST_RD_REQ)  || (state_reg == ST_RD_WAIT) ||
                   (state_reg == ST_WR_REQ)  || (state_reg == ST_WR_WAIT);
    assign error = error_reg;

endmodule
